// File: rtl/mem_arbiter_2to1.sv
// Two-port (instruction/data) arbiter in front of a single-port synchronous RAM.
// Round-robin with a hold-lock under backpressure, and in-order read-response routing.
module mem_arbiter_2to1 #(
  parameter int AddrWidth      = 32,
  parameter int DataWidth      = 32,
  parameter int MaxOutstanding = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   inst_valid_i,
  output logic                   inst_ready_o,
  input  logic [AddrWidth-1:0]   inst_addr_i,
  input  logic [DataWidth-1:0]   inst_wdata_i,
  input  logic [DataWidth/8-1:0] inst_wmask_i,
  output logic [DataWidth-1:0]   inst_rdata_o,
  output logic                   inst_rvalid_o,
  input  logic                   data_valid_i,
  output logic                   data_ready_o,
  input  logic [AddrWidth-1:0]   data_addr_i,
  input  logic [DataWidth-1:0]   data_wdata_i,
  input  logic [DataWidth/8-1:0] data_wmask_i,
  output logic [DataWidth-1:0]   data_rdata_o,
  output logic                   data_rvalid_o,
  output logic                   mem_valid_o,
  input  logic                   mem_ready_i,
  output logic [AddrWidth-1:0]   mem_addr_o,
  output logic [DataWidth-1:0]   mem_wdata_o,
  output logic [DataWidth/8-1:0] mem_wmask_o,
  input  logic [DataWidth-1:0]   mem_rdata_i,
  input  logic                   mem_rvalid_i,
  output logic                   error_o
);

  localparam int PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam logic [2:0] MaxCnt = 3'(MaxOutstanding);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(MaxOutstanding - 1);

  typedef enum logic {PortInst = 1'b0, PortData = 1'b1} port_e;

  logic            lock_q;
  port_e           lock_port_q;
  logic            prefer_data_q;
  logic [2:0]      count_q;
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  port_e           route_q [MaxOutstanding];
  logic            error_q;

  logic  sel_any, sel_valid, sel_read, handshake, push, pop;
  port_e sel_port, route_head;

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

  // A locked grant must keep its port even if the other side becomes the tie winner.
  always_comb begin
    sel_any  = 1'b0;
    sel_port = PortInst;
    if (lock_q) begin
      sel_any  = 1'b1;
      sel_port = lock_port_q;
    end else if (inst_valid_i && data_valid_i) begin
      sel_any  = 1'b1;
      sel_port = prefer_data_q ? PortData : PortInst;
    end else if (data_valid_i) begin
      sel_any  = 1'b1;
      sel_port = PortData;
    end else if (inst_valid_i) begin
      sel_any  = 1'b1;
      sel_port = PortInst;
    end
  end

  always_comb begin
    sel_valid   = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_wmask_o = '0;
    if (sel_any) begin
      if (sel_port == PortData) begin
        sel_valid   = data_valid_i;
        mem_addr_o  = data_addr_i;
        mem_wdata_o = data_wdata_i;
        mem_wmask_o = data_wmask_i;
      end else begin
        sel_valid   = inst_valid_i;
        mem_addr_o  = inst_addr_i;
        mem_wdata_o = inst_wdata_i;
        mem_wmask_o = inst_wmask_i;
      end
    end
  end

  // Only reads are throttled by the outstanding count; writes never wait on it.
  assign sel_read     = (mem_wmask_o == '0);
  assign mem_valid_o  = rst_ni & sel_any & sel_valid & ~(sel_read & (count_q == MaxCnt));
  assign handshake    = mem_valid_o & mem_ready_i;
  assign inst_ready_o = handshake & (sel_port == PortInst);
  assign data_ready_o = handshake & (sel_port == PortData);

  assign push       = handshake & sel_read;
  assign pop        = mem_rvalid_i & (count_q != 3'd0);
  assign route_head = route_q[rd_ptr_q];

  assign inst_rvalid_o = rst_ni & pop & (route_head == PortInst);
  assign data_rvalid_o = rst_ni & pop & (route_head == PortData);
  assign inst_rdata_o  = mem_rdata_i;
  assign data_rdata_o  = mem_rdata_i;
  assign error_o       = error_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q        <= 1'b0;
      lock_port_q   <= PortInst;
      prefer_data_q <= 1'b1;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      error_q       <= 1'b0;
    end else begin
      if (handshake) begin
        lock_q        <= 1'b0;
        prefer_data_q <= (sel_port == PortInst);
      end else if (mem_valid_o) begin
        lock_q      <= 1'b1;
        lock_port_q <= sel_port;
      end
      if (push) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_q <= count_q + 3'd1;
        2'b01:   count_q <= count_q - 3'd1;
        default: count_q <= count_q;
      endcase
      if (mem_rvalid_i && count_q == 3'd0) error_q <= 1'b1;
    end
  end

  // Route storage needs no reset: entries are only read when counted valid.
  always_ff @(posedge clk_i) begin
    if (push) route_q[wr_ptr_q] <= sel_port;
  end

endmodule
